// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register over DEPTH stages with
// valid tracking, stall/flush, $zero write suppression and a bubble counter.
module mem_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int DEPTH         = 1,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              jump_reg,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] reg_address,
  output logic              out_valid,
  output logic              reg_write_out,
  output logic              jump_reg_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] result_out,
  output logic [ADDR_W-1:0] reg_address_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       bubble_count
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              jr;
    logic              m2r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] res;
  } stage_t;

  stage_t      stage_q [DEPTH];
  stage_t      stage_d [DEPTH];
  stage_t      cap;
  stage_t      last;
  logic        zero_hit;
  logic [15:0] bubble_count_q;
  logic [15:0] bubble_count_d;

  assign zero_hit = (ZERO_SUPPRESS != 0) && (reg_address == '0);

  always_comb begin
    cap       = '0;
    cap.valid = in_valid;
    cap.rw    = reg_write & in_valid & ~zero_hit;
    cap.jr    = jump_reg & in_valid;
    cap.m2r   = mem_to_reg;
    cap.addr  = reg_address;
    cap.data  = data;
    cap.res   = ALU_result;
  end

  assign last = stage_q[DEPTH-1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    bubble_count_d = bubble_count_q;
    if (!stall) begin
      stage_d[0] = cap;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
    // flush wins over stall for stage 0 only
    if (flush) begin
      stage_d[0] = '0;
    end
    if (!stall && !last.valid && bubble_count_q != 16'hFFFF) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      bubble_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      bubble_count_q <= bubble_count_d;
    end
  end

  assign out_valid       = last.valid;
  assign reg_write_out   = last.rw;
  assign jump_reg_out    = last.jr;
  assign data_out        = last.data;
  assign result_out      = last.res;
  assign reg_address_out = last.addr;
  assign wb_data         = last.m2r ? last.data : last.res;
  assign bubble_count    = bubble_count_q;

endmodule
